// File: rtl/lcd_cmd_sched.sv
// Command scheduler in front of LCD_CTRL: two-requester round-robin intake into a
// command FIFO, single-command issue handshake, and Write/done session tracking.
//
// state     | meaning
// IDLE      | waiting for a queued command; loads queue head onto cmd
// ISSUE     | cmd_valid high, waiting for busy==0 to hand the command over
// COOLDOWN  | one forced cmd_valid-low cycle between commands
// WAIT_DONE | Write issued; waiting for done or timeout before issuing again
module lcd_cmd_sched #(
   parameter int DEPTH   = 8,
   parameter int AW      = 3,
   parameter int TIMEOUT = 1023
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [2:0]    a_cmd,
   input  logic          a_valid,
   output logic          a_ready,
   input  logic [2:0]    b_cmd,
   input  logic          b_valid,
   output logic          b_ready,
   output logic [2:0]    cmd,
   output logic          cmd_valid,
   input  logic          busy,
   input  logic          done,
   output logic [AW:0]   q_count,
   output logic          session_done,
   output logic          timeout_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, COOLDOWN, WAIT_DONE} state_t;

   localparam int            TW   = $clog2(TIMEOUT + 1);
   localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);
   localparam logic [TW-1:0] TC   = TW'(TIMEOUT - 1);

   logic [2:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic          prio_b;
   state_t        state, state_nxt;
   logic [TW-1:0] timer, timer_nxt;
   logic [2:0]    cmd_nxt, push_data;
   logic          cmd_valid_nxt, pop, sd_nxt, err_set;
   logic          can_accept, both, push;

   // Ready is gated by reset so nothing appears accepted while the queue is being cleared.
   always_comb begin
      a_ready    = 1'b0;
      b_ready    = 1'b0;
      can_accept = reset && (q_count != FULL);
      both       = a_valid && b_valid;
      if (can_accept) begin
         if (both) begin
            if (prio_b) b_ready = 1'b1;
            else        a_ready = 1'b1;
         end else if (a_valid) begin
            a_ready = 1'b1;
         end else if (b_valid) begin
            b_ready = 1'b1;
         end
      end
      push      = a_ready || b_ready;
      push_data = a_ready ? a_cmd : b_cmd;
   end

   always_comb begin
      state_nxt     = state;
      cmd_nxt       = cmd;
      cmd_valid_nxt = cmd_valid;
      pop           = 1'b0;
      sd_nxt        = 1'b0;
      err_set       = 1'b0;
      timer_nxt     = '0;
      case (state)
         IDLE: begin
            if (q_count != '0) begin
               cmd_nxt       = mem[rd_ptr];
               cmd_valid_nxt = 1'b1;
               state_nxt     = ISSUE;
            end
         end
         ISSUE: begin
            if (!busy) begin
               pop           = 1'b1;
               cmd_valid_nxt = 1'b0;
               state_nxt     = (cmd == 3'd0) ? WAIT_DONE : COOLDOWN;
            end
         end
         COOLDOWN: state_nxt = IDLE;
         WAIT_DONE: begin
            if (done) begin
               sd_nxt    = 1'b1;
               state_nxt = IDLE;
            end else if (timer == TC) begin
               err_set   = 1'b1;
               state_nxt = IDLE;
            end else begin
               timer_nxt = timer + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state        <= IDLE;
         cmd          <= '0;
         cmd_valid    <= 1'b0;
         session_done <= 1'b0;
         timeout_err  <= 1'b0;
         timer        <= '0;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         q_count      <= '0;
         prio_b       <= 1'b0;
      end else begin
         state        <= state_nxt;
         cmd          <= cmd_nxt;
         cmd_valid    <= cmd_valid_nxt;
         session_done <= sd_nxt;
         timeout_err  <= timeout_err | err_set;
         timer        <= timer_nxt;
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   q_count <= q_count + 1'b1;
            2'b01:   q_count <= q_count - 1'b1;
            default: ;
         endcase
         if (both && can_accept) prio_b <= ~prio_b;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: tb/tb_lcd_cmd_sched.sv
// Bench for lcd_cmd_sched: a negedge monitor predicts ready/q_count and scoreboards
// every command handed to LCD_CTRL; scenario tasks add their own timing checks.
module tb_lcd_cmd_sched;
   localparam int DEPTH = 8, AW = 3, TIMEOUT = 15;

   logic          clk = 1'b0, reset = 1'b0;
   logic [2:0]    a_cmd = '0, b_cmd = '0;
   logic          a_valid = 1'b0, b_valid = 1'b0, busy = 1'b0, done = 1'b0;
   logic          a_ready, b_ready, cmd_valid, session_done, timeout_err;
   logic [2:0]    cmd;
   logic [AW:0]   q_count;

   int            n_tests = 0, n_fail = 0;
   logic          mon_en = 1'b0;
   logic [2:0]    sb[$];
   int            mcount = 0;
   logic          mptr = 1'b0;
   logic          m_ea, m_eb, m_pop;
   logic [2:0]    m_exp;

   lcd_cmd_sched #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .a_cmd(a_cmd), .a_valid(a_valid), .a_ready(a_ready),
      .b_cmd(b_cmd), .b_valid(b_valid), .b_ready(b_ready),
      .cmd(cmd), .cmd_valid(cmd_valid), .busy(busy), .done(done),
      .q_count(q_count), .session_done(session_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   // Inputs only change at posedge+1, so negedge values are what the next edge samples.
   always @(negedge clk) begin
      if (mon_en) begin
         m_ea = 1'b0;
         m_eb = 1'b0;
         if (reset && mcount < DEPTH) begin
            if (a_valid && b_valid) begin
               if (mptr) m_eb = 1'b1;
               else      m_ea = 1'b1;
            end else if (a_valid) m_ea = 1'b1;
            else if (b_valid)     m_eb = 1'b1;
         end
         n_tests++;
         if (a_ready !== m_ea || b_ready !== m_eb) begin
            n_fail++;
            $display("FAIL ready: got a=%0b b=%0b expected a=%0b b=%0b at %0t", a_ready, b_ready, m_ea, m_eb, $time);
         end
         n_tests++;
         if (q_count !== mcount[AW:0]) begin
            n_fail++;
            $display("FAIL q_count: got %0d expected %0d at %0t", q_count, mcount, $time);
         end
         if (!reset) begin
            sb.delete();
            mcount = 0;
            mptr   = 1'b0;
         end else begin
            m_pop = cmd_valid && !busy;
            if (m_pop) begin
               n_tests++;
               if (sb.size() == 0) begin
                  n_fail++;
                  $display("FAIL issue_order: got cmd %0d expected no command at %0t", cmd, $time);
               end else begin
                  m_exp = sb.pop_front();
                  if (cmd !== m_exp) begin
                     n_fail++;
                     $display("FAIL issue_order: got cmd %0d expected %0d at %0t", cmd, m_exp, $time);
                  end
               end
            end
            if (m_ea)      sb.push_back(a_cmd);
            else if (m_eb) sb.push_back(b_cmd);
            if (a_valid && b_valid && (m_ea || m_eb)) mptr = ~mptr;
            mcount = mcount + ((m_ea || m_eb) ? 1 : 0) - (m_pop ? 1 : 0);
         end
      end
   end

   task automatic test_reset();
      int bad = 0;
      reset = 1'b0; a_valid = 1'b1; a_cmd = 3'd5;
      @(posedge clk); #1; mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (a_ready !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      reset = 1'b1; a_valid = 1'b0;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL reset_ready: got %0d high cycles expected 0", bad); end
      @(negedge clk);
      n_tests++; if (cmd_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_cmd_valid: got %0b expected 0", cmd_valid); end
      n_tests++; if (q_count !== '0)       begin n_fail++; $display("FAIL reset_q_count: got %0d expected 0", q_count); end
      n_tests++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
      @(posedge clk); #1;
   endtask

   task automatic test_single_source();
      logic [2:0] vals [3] = '{3'd3, 3'd1, 3'd5};
      int peak = 0, pulses = 0, hi = 0, hi_max = 0, bad = 0;
      logic prev = 1'b0;
      busy = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (c < 3) begin a_valid = 1'b1; a_cmd = vals[c]; end
         else a_valid = 1'b0;
         @(negedge clk);
         if (c < 3 && a_ready !== 1'b1) bad++;
         if (int'(q_count) > peak) peak = int'(q_count);
         if (cmd_valid) begin
            if (!prev) pulses++;
            hi++;
            if (hi > hi_max) hi_max = hi;
         end else hi = 0;
         prev = cmd_valid;
         @(posedge clk); #1;
      end
      n_tests++; if (bad != 0)    begin n_fail++; $display("FAIL single_ready: got %0d refusals expected 0", bad); end
      n_tests++; if (pulses != 3) begin n_fail++; $display("FAIL single_pulses: got %0d expected 3", pulses); end
      n_tests++; if (hi_max != 1) begin n_fail++; $display("FAIL single_pulse_width: got %0d expected 1", hi_max); end
      n_tests++; if (peak < 2 || peak > 3) begin n_fail++; $display("FAIL single_peak: got %0d expected 2..3", peak); end
      n_tests++; if (q_count !== '0) begin n_fail++; $display("FAIL single_drain: got %0d expected 0", q_count); end
   endtask

   task automatic test_contention();
      logic [7:0] seq = '0;
      int acc = 0, n = 0;
      busy = 1'b1; a_valid = 1'b1; b_valid = 1'b1; a_cmd = 3'd6; b_cmd = 3'd7;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (a_ready || b_ready) begin
            if (acc < 8) seq[acc] = b_ready;
            acc++;
         end
         @(posedge clk); #1;
      end
      n_tests++; if (acc != 8)      begin n_fail++; $display("FAIL contention_accepts: got %0d expected 8", acc); end
      n_tests++; if (seq !== 8'hAA) begin n_fail++; $display("FAIL contention_order: got %0h expected aa", seq); end
      @(negedge clk);
      n_tests++; if (q_count !== 4'd8 || a_ready !== 1'b0 || b_ready !== 1'b0) begin
         n_fail++; $display("FAIL contention_full: got q=%0d a=%0b b=%0b expected q=8 a=0 b=0", q_count, a_ready, b_ready);
      end
      @(posedge clk); #1; busy = 1'b0;
      @(posedge clk); #1; busy = 1'b1;
      @(negedge clk);
      n_tests++; if (q_count !== 4'd7 || (a_ready ^ b_ready) !== 1'b1) begin
         n_fail++; $display("FAIL contention_refill: got q=%0d a=%0b b=%0b expected q=7 one ready", q_count, a_ready, b_ready);
      end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++; if (q_count !== 4'd8) begin n_fail++; $display("FAIL contention_refull: got %0d expected 8", q_count); end
      @(posedge clk); #1;
      a_valid = 1'b0; b_valid = 1'b0; busy = 1'b0;
      do begin @(posedge clk); #1; @(negedge clk); n++; end
      while ((q_count !== '0 || cmd_valid !== 1'b0) && n < 120);
      n_tests++; if (q_count !== '0 || cmd_valid !== 1'b0) begin n_fail++; $display("FAIL contention_drain: got q=%0d expected 0", q_count); end
      @(posedge clk); #1;
   endtask

   task automatic test_busy_stall();
      int bad = 0;
      busy = 1'b1; a_valid = 1'b1; a_cmd = 3'd4;
      @(posedge clk); #1; a_valid = 1'b0;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (cmd_valid !== 1'b1 || cmd !== 3'd4) bad++;
         @(posedge clk); #1;
      end
      busy = 1'b0;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stall_hold: got %0d bad cycles expected 0", bad); end
      @(posedge clk); #1;
      @(negedge clk);
      n_tests++; if (cmd_valid !== 1'b0 || q_count !== '0) begin
         n_fail++; $display("FAIL stall_pop: got valid=%0b q=%0d expected valid=0 q=0", cmd_valid, q_count);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_done();
      logic [2:0] vals [3] = '{3'd2, 3'd0, 3'd3};
      int bad = 0, n = 0;
      logic found = 1'b0;
      busy = 1'b0; done = 1'b0;
      for (int i = 0; i < 3; i++) begin a_valid = 1'b1; a_cmd = vals[i]; @(posedge clk); #1; end
      a_valid = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         @(negedge clk);
         if (cmd_valid && cmd == 3'd0) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL write_issue: got no Write within 30 cycles expected Write"); end
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1; @(negedge clk);
         if (cmd_valid !== 1'b0 || session_done !== 1'b0) bad++;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL write_hold: got %0d issue cycles expected 0", bad); end
      @(posedge clk); #1; done = 1'b1;
      @(posedge clk); #1; done = 1'b0;
      @(negedge clk);
      n_tests++; if (session_done !== 1'b1) begin n_fail++; $display("FAIL session_pulse: got %0b expected 1", session_done); end
      @(posedge clk); #1; @(negedge clk);
      n_tests++; if (session_done !== 1'b0 || cmd_valid !== 1'b1 || cmd !== 3'd3) begin
         n_fail++; $display("FAIL after_done: got sd=%0b valid=%0b cmd=%0d expected sd=0 valid=1 cmd=3", session_done, cmd_valid, cmd);
      end
      do begin @(posedge clk); #1; @(negedge clk); n++; end
      while ((q_count !== '0 || cmd_valid !== 1'b0) && n < 50);
      repeat (3) @(posedge clk);
      #1; done = 1'b1;
      @(posedge clk); #1; done = 1'b0;
      bad = 0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (session_done !== 1'b0) bad++;
         @(posedge clk); #1;
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL idle_done: got %0d pulses expected 0", bad); end
   endtask

   task automatic test_timeout_reset();
      int bad = 0;
      logic found = 1'b0;
      busy = 1'b0; a_valid = 1'b1; a_cmd = 3'd0;
      @(posedge clk); #1; a_valid = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         @(negedge clk);
         if (cmd_valid && cmd == 3'd0) found = 1'b1;
         else begin @(posedge clk); #1; end
      end
      n_tests++; if (!found) begin n_fail++; $display("FAIL timeout_issue: got no Write within 20 cycles expected Write"); end
      @(posedge clk); #1; a_valid = 1'b1; a_cmd = 3'd1;
      @(posedge clk); #1; a_valid = 1'b0;
      for (int k = 2; k <= 16; k++) begin
         @(posedge clk); #1;
         if (k == 16) busy = 1'b1;
         @(negedge clk);
         if (k <= 14 && (timeout_err !== 1'b0 || cmd_valid !== 1'b0)) bad++;
         if (k == 15) begin
            n_tests++; if (timeout_err !== 1'b1) begin n_fail++; $display("FAIL timeout_flag: got %0b expected 1", timeout_err); end
         end
         if (k == 16) begin
            n_tests++; if (cmd_valid !== 1'b1 || cmd !== 3'd1) begin
               n_fail++; $display("FAIL timeout_resume: got valid=%0b cmd=%0d expected valid=1 cmd=1", cmd_valid, cmd);
            end
         end
      end
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL timeout_early: got %0d bad cycles expected 0", bad); end
      @(posedge clk); #1; a_valid = 1'b1; a_cmd = 3'd2;
      @(posedge clk); #1; a_cmd = 3'd3;
      @(posedge clk); #1; a_cmd = 3'd4;
      @(posedge clk); #1; a_valid = 1'b0;
      @(negedge clk);
      n_tests++; if (q_count !== 4'd4) begin n_fail++; $display("FAIL pre_reset_count: got %0d expected 4", q_count); end
      @(posedge clk); #1; reset = 1'b0;
      @(posedge clk); #1; reset = 1'b1;
      @(negedge clk);
      n_tests++; if (q_count !== '0 || cmd_valid !== 1'b0 || timeout_err !== 1'b0) begin
         n_fail++; $display("FAIL mid_reset: got q=%0d valid=%0b err=%0b expected 0 0 0", q_count, cmd_valid, timeout_err);
      end
      @(posedge clk); #1; busy = 1'b0;
   endtask

   task automatic test_b_only();
      int bad = 0, n = 0;
      b_valid = 1'b1; b_cmd = 3'd5;
      @(negedge clk); if (b_ready !== 1'b1 || a_ready !== 1'b0) bad++;
      @(posedge clk); #1; b_cmd = 3'd2;
      @(negedge clk); if (b_ready !== 1'b1 || a_ready !== 1'b0) bad++;
      @(posedge clk); #1; b_valid = 1'b0;
      n_tests++; if (bad != 0) begin n_fail++; $display("FAIL b_ready: got %0d refusals expected 0", bad); end
      do begin @(posedge clk); #1; @(negedge clk); n++; end
      while ((q_count !== '0 || cmd_valid !== 1'b0) && n < 50);
      n_tests++; if (q_count !== '0 || sb.size() != 0) begin
         n_fail++; $display("FAIL b_drain: got q=%0d pending=%0d expected 0 0", q_count, sb.size());
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single_source();
      test_contention();
      test_busy_stall();
      test_write_done();
      test_timeout_reset();
      test_b_only();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
